// File: rtl/atm_pin_keypad_if.sv
// Keypad <-> session bus for the ATM PIN front end.
// Card/key inputs in, authorisation status out.
interface atm_pin_keypad_if #(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 3
);
  localparam int DC_W = $clog2(DIGITS + 1);
  localparam int TL_W = $clog2(MAX_TRIES + 1);

  logic            in_card;
  logic            in_key_valid;
  logic [3:0]      in_key_code;
  logic            pin_valid;
  logic            pin_ok;
  logic            pin_fail;
  logic            session_timeout;
  logic            card_retain;
  logic [DC_W-1:0] digit_count;
  logic [TL_W-1:0] tries_left;

  modport master (
    output in_card, in_key_valid, in_key_code,
    input  pin_valid, pin_ok, pin_fail,
    input  session_timeout, card_retain,
    input  digit_count, tries_left
  );

  modport slave (
    input  in_card, in_key_valid, in_key_code,
    output pin_valid, pin_ok, pin_fail,
    output session_timeout, card_retain,
    output digit_count, tries_left
  );
endinterface

// File: rtl/atm_pin_keypad.sv
// ATM PIN keypad: digit collection, PIN check,
// retry/lockout tracking and inactivity abort.
module atm_pin_keypad #(
  parameter int                  DIGITS     = 4,
  parameter int                  MAX_TRIES  = 3,
  parameter logic [4*DIGITS-1:0] STORED_PIN = 16'h1111,
  parameter int                  TIMEOUT    = 200,
  parameter int                  TIMER_W    = 8
) (
  input logic              clk,
  input logic              rst,
  atm_pin_keypad_if.slave  bus
);
  localparam int DC_W = $clog2(DIGITS + 1);
  localparam int TL_W = $clog2(MAX_TRIES + 1);
  localparam int BW   = 4 * DIGITS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_GRANTED = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  localparam logic [DC_W-1:0]    FULL   = DC_W'(DIGITS);
  localparam logic [TL_W-1:0]    TRIES0 = TL_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(TIMEOUT - 1);

  logic [2:0]         state;
  logic [BW-1:0]      pin_buf;
  logic [DC_W-1:0]    count;
  logic [TL_W-1:0]    tries;
  logic [TIMER_W-1:0] timer;
  logic               valid_q;
  logic               ok_q;
  logic               fail_q;
  logic               tmo_q;
  logic               retain_q;

  logic key_digit;
  logic key_clear;
  logic key_enter;
  logic full;
  logic match;
  logic tmo_hit;

  // Key classification and check helpers
  always_comb begin
    key_digit = bus.in_key_code <= 4'd9;
    key_clear = bus.in_key_code == 4'hC;
    key_enter = bus.in_key_code == 4'hE;
    full      = count == FULL;
    match     = pin_buf == STORED_PIN;
    tmo_hit   = timer == T_LAST;
  end

  // Session FSM with registered status outputs;
  // the PIN buffer is wiped on every exit path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pin_buf  <= '0;
      count    <= '0;
      tries    <= TRIES0;
      timer    <= '0;
      valid_q  <= 1'b0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
      retain_q <= 1'b0;
    end else begin
      ok_q   <= 1'b0;
      fail_q <= 1'b0;
      tmo_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_card) begin
            state   <= S_COLLECT;
            pin_buf <= '0;
            count   <= '0;
            timer   <= '0;
            tries   <= TRIES0;
          end
        end
        S_COLLECT: begin
          if (!bus.in_card) begin
            state   <= S_IDLE;
            pin_buf <= '0;
            count   <= '0;
            timer   <= '0;
            tries   <= TRIES0;
          end else if (bus.in_key_valid) begin
            timer <= '0;
            unique case (1'b1)
              key_digit: begin
                if (!full) begin
                  pin_buf <= {pin_buf[BW-5:0],
                              bus.in_key_code};
                  count   <= count + 1'b1;
                end
              end
              key_clear: begin
                pin_buf <= '0;
                count   <= '0;
              end
              key_enter: begin
                if (full) state <= S_CHECK;
              end
              default: ;
            endcase
          end else if (tmo_hit) begin
            tmo_q   <= 1'b1;
            state   <= S_IDLE;
            pin_buf <= '0;
            count   <= '0;
            timer   <= '0;
            tries   <= TRIES0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHECK: begin
          pin_buf <= '0;
          count   <= '0;
          timer   <= '0;
          if (!bus.in_card) begin
            state <= S_IDLE;
            tries <= TRIES0;
          end else if (match) begin
            ok_q    <= 1'b1;
            valid_q <= 1'b1;
            state   <= S_GRANTED;
          end else begin
            fail_q <= 1'b1;
            tries  <= tries - 1'b1;
            if (tries == TL_W'(1)) begin
              retain_q <= 1'b1;
              state    <= S_LOCKED;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_GRANTED: begin
          if (!bus.in_card) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
            tries   <= TRIES0;
          end
        end
        S_LOCKED: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pin_valid       = valid_q;
  assign bus.pin_ok          = ok_q;
  assign bus.pin_fail        = fail_q;
  assign bus.session_timeout = tmo_q;
  assign bus.card_retain     = retain_q;
  assign bus.digit_count     = count;
  assign bus.tries_left      = tries;
endmodule

// File: tb/tb_atm_pin_keypad.sv
// Bench for atm_pin_keypad: vector table, directed
// corner sequences and random keys vs a queue model.
module tb_atm_pin_keypad;
  localparam int DIGITS    = 4;
  localparam int MAX_TRIES = 3;
  localparam int TIMEOUT   = 200;
  localparam logic [15:0] PIN = 16'h1111;

  localparam int P_OFF    = 0;
  localparam int P_ENTRY  = 1;
  localparam int P_VERIFY = 2;
  localparam int P_AUTH   = 3;
  localparam int P_HELD   = 4;

  logic clk = 1'b0;
  logic rst;

  atm_pin_keypad_if #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)
  ) bus ();

  atm_pin_keypad #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES),
    .STORED_PIN(PIN), .TIMEOUT(TIMEOUT),
    .TIMER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_phase;
  int q[$];
  int m_idle;
  int m_tries;
  bit m_valid, m_ok, m_fail, m_to, m_ret;

  typedef struct {
    bit card; bit kv; int code;
    bit valid; bit ok; bit fail; bit ret;
    int cnt; int tries;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_OFF;
    q.delete();
    m_idle  = 0;
    m_tries = MAX_TRIES;
    m_valid = 0; m_ok = 0; m_fail = 0;
    m_to = 0; m_ret = 0;
  endfunction

  function automatic void leave();
    m_phase = P_OFF;
    q.delete();
    m_idle  = 0;
    m_tries = MAX_TRIES;
  endfunction

  function automatic logic [31:0] pin_value();
    logic [31:0] v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  function automatic void model_step(bit card,
                                     bit kv,
                                     int code);
    m_ok = 0; m_fail = 0; m_to = 0;
    case (m_phase)
      P_OFF: if (card) begin
        m_phase = P_ENTRY;
        q.delete();
        m_idle  = 0;
        m_tries = MAX_TRIES;
      end
      P_ENTRY: begin
        if (!card) leave();
        else if (kv) begin
          m_idle = 0;
          if (code < 10) begin
            if (q.size() < DIGITS) q.push_back(code);
          end else if (code == 12) q.delete();
          else if (code == 14 && q.size() == DIGITS)
            m_phase = P_VERIFY;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_to = 1;
            leave();
          end
        end
      end
      P_VERIFY: begin
        if (!card) leave();
        else begin
          if (pin_value() == PIN) begin
            m_ok = 1; m_valid = 1;
            m_phase = P_AUTH;
          end else begin
            m_fail = 1;
            m_tries--;
            m_idle = 0;
            if (m_tries == 0) begin
              m_ret = 1;
              m_phase = P_HELD;
            end else m_phase = P_ENTRY;
          end
          q.delete();
        end
      end
      P_AUTH: if (!card) begin
        m_valid = 0;
        leave();
      end
      default: ;
    endcase
  endfunction

  task automatic compare_all(string t);
    chk({t, ".pin_valid"}, bus.pin_valid, m_valid);
    chk({t, ".pin_ok"}, bus.pin_ok, m_ok);
    chk({t, ".pin_fail"}, bus.pin_fail, m_fail);
    chk({t, ".timeout"}, bus.session_timeout, m_to);
    chk({t, ".retain"}, bus.card_retain, m_ret);
    chk({t, ".count"}, bus.digit_count, q.size());
    chk({t, ".tries"}, bus.tries_left, m_tries);
    chk({t, ".ok_fail_excl"},
        bus.pin_ok & bus.pin_fail, 0);
    chk({t, ".valid_ret_excl"},
        bus.pin_valid & bus.card_retain, 0);
  endtask

  task automatic step(bit card, bit kv, int code);
    logic [31:0] c = code;
    bus.in_card      = card;
    bus.in_key_valid = kv;
    bus.in_key_code  = c[3:0];
    @(posedge clk);
    model_step(card, kv, code);
    @(negedge clk);
    compare_all("model");
    bus.in_key_valid = 1'b0;
  endtask

  task automatic keys4(int a, int b, int c, int d);
    step(1, 1, a); step(1, 1, b);
    step(1, 1, c); step(1, 1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic void add(bit c, bit k, int cd,
                              bit v, bit o, bit f,
                              bit r, int n, int t);
    vec_t e;
    e.card = c; e.kv = k; e.code = cd;
    e.valid = v; e.ok = o; e.fail = f; e.ret = r;
    e.cnt = n; e.tries = t;
    tbl.push_back(e);
  endfunction

  initial begin
    add(1,0,0,  0,0,0,0,0,3);
    add(1,1,1,  0,0,0,0,1,3);
    add(1,1,1,  0,0,0,0,2,3);
    add(1,1,1,  0,0,0,0,3,3);
    add(1,1,1,  0,0,0,0,4,3);
    add(1,1,14, 0,0,0,0,4,3);
    add(1,0,0,  1,1,0,0,0,3);
    add(1,0,0,  1,0,0,0,0,3);
    add(0,0,0,  0,0,0,0,0,3);
    add(1,0,0,  0,0,0,0,0,3);
    add(1,1,1,  0,0,0,0,1,3);
    add(1,1,2,  0,0,0,0,2,3);
    add(1,1,3,  0,0,0,0,3,3);
    add(1,1,4,  0,0,0,0,4,3);
    add(1,1,14, 0,0,0,0,4,3);
    add(1,0,0,  0,0,1,0,0,2);
    add(1,1,1,  0,0,0,0,1,2);
    add(1,1,1,  0,0,0,0,2,2);
    add(1,1,1,  0,0,0,0,3,2);
    add(1,1,1,  0,0,0,0,4,2);
    add(1,1,14, 0,0,0,0,4,2);
    add(1,0,0,  1,1,0,0,0,2);
    add(0,0,0,  0,0,0,0,0,3);

    bus.in_card = 0;
    bus.in_key_valid = 0;
    bus.in_key_code = 0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all("reset0");
    chk("reset.tries", bus.tries_left, MAX_TRIES);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      string t = $sformatf("vec%0d", i);
      step(tbl[i].card, tbl[i].kv, tbl[i].code);
      chk({t, ".valid"}, bus.pin_valid, tbl[i].valid);
      chk({t, ".ok"}, bus.pin_ok, tbl[i].ok);
      chk({t, ".fail"}, bus.pin_fail, tbl[i].fail);
      chk({t, ".ret"}, bus.card_retain, tbl[i].ret);
      chk({t, ".cnt"}, bus.digit_count, tbl[i].cnt);
      chk({t, ".tries"}, bus.tries_left, tbl[i].tries);
    end

    step(1, 0, 0);
    repeat (3) begin
      keys4(9, 9, 9, 9);
      step(1, 1, 14);
      step(1, 0, 0);
      chk("wrong.fail", bus.pin_fail, 1);
    end
    chk("lock.retain", bus.card_retain, 1);
    chk("lock.tries", bus.tries_left, 0);
    keys4(1, 1, 1, 1);
    step(1, 1, 14);
    step(0, 0, 0);
    step(0, 1, 1);
    chk("lock.held", bus.card_retain, 1);
    chk("lock.no_ok", bus.pin_ok, 0);
    do_reset();
    chk("unlock.retain", bus.card_retain, 0);

    step(1, 0, 0);
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
    step(1, 1, 14);
    chk("short_enter.cnt", bus.digit_count, 3);
    step(1, 1, 1); step(1, 1, 5);
    chk("overflow.cnt", bus.digit_count, 4);
    step(1, 1, 12);
    chk("clear.cnt", bus.digit_count, 0);
    keys4(1, 1, 1, 1);
    step(1, 1, 14);
    step(1, 0, 0);
    chk("after_clear.ok", bus.pin_ok, 1);
    step(0, 0, 0);

    step(1, 0, 0);
    step(1, 1, 1); step(1, 1, 1);
    repeat (TIMEOUT - 1) step(1, 0, 0);
    chk("tmo.early", bus.session_timeout, 0);
    step(1, 0, 0);
    chk("tmo.pulse", bus.session_timeout, 1);
    chk("tmo.cnt", bus.digit_count, 0);
    step(1, 0, 0);
    chk("tmo.single", bus.session_timeout, 0);
    step(1, 1, 1);
    repeat (TIMEOUT - 1) step(1, 0, 0);
    step(1, 1, 4'hA);
    chk("tmo.key_wins", bus.session_timeout, 0);
    chk("tmo.key_cnt", bus.digit_count, 1);
    step(1, 0, 0);
    chk("tmo.after_key", bus.session_timeout, 0);

    step(1, 1, 12);
    keys4(1, 1, 1, 1);
    step(0, 1, 14);
    step(0, 0, 0);
    chk("drop.no_ok", bus.pin_ok, 0);
    chk("drop.valid", bus.pin_valid, 0);

    step(1, 0, 0);
    step(1, 1, 1); step(1, 1, 1);
    do_reset();
    chk("async.cnt", bus.digit_count, 0);
    chk("async.tries", bus.tries_left, MAX_TRIES);

    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 7);
      int code;
      if (r < 4) code = 1;
      else if (r == 4) code = 14;
      else if (r == 5) code = 12;
      else code = $urandom_range(0, 15);
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 39) != 0,
                $urandom_range(0, 2) == 0, code);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
